// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and sizes for the sequential 32x32 multiplier
//
// Purpose:
//   Holds the multiplier controller state encoding and the datapath sizes
//   used by mul32_seq_ctrl.
//   No ports: this is a package.
package mul_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } mul_state_t;

  localparam int MUL_W     = 32;
  localparam int MUL_ITERS = 32;
  localparam int MUL_CNT_W = 6;

endpackage

// File: rtl/add32.sv
// rtl/add32.sv - 32-bit ripple-carry adder built from single-bit full adders
//
// Purpose:
//   Plain ripple adder. The multiplier shares one instance of it across all
//   iterations.
// Ports (full_adder):
//   a, b, c_in  in   1   addend bits and carry in
//   sum         out  1   sum bit
//   c_out       out  1   carry out
// Ports (add32):
//   a, b        in   32  addends
//   c_in        in   1   carry into bit 0
//   sum         out  32  a + b + c_in, low 32 bits
//   c_out       out  1   carry out of bit 31
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [32:0] w_carry;

  assign w_carry[0] = c_in;

  for (genvar g = 0; g < 32; g++) begin : g_bit
    full_adder u_fa (
      .a     (a[g]),
      .b     (b[g]),
      .c_in  (w_carry[g]),
      .sum   (sum[g]),
      .c_out (w_carry[g+1])
    );
  end

  assign c_out = w_carry[32];

endmodule

// File: rtl/mul32_seq_ctrl.sv
// rtl/mul32_seq_ctrl.sv - shift-and-add sequential 32x32 -> 64 unsigned multiplier
//
// Purpose:
//   Multi-cycle functional unit: accepts an operand pair, runs 32 iterations
//   of conditional-add-then-shift through a single shared add32, and presents
//   the 64-bit product with a valid/ready handshake. With ZERO_SKIP set, a
//   zero operand produces product 0 one cycle after accept.
// Ports:
//   clk        in   1   clock, all state on posedge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   operand pair valid
//   in_ready   out  1   idle and not in reset
//   a          in   32  multiplicand, sampled on accept
//   b          in   32  multiplier, sampled on accept
//   out_valid  out  1   product valid (registered)
//   out_ready  in   1   consumer takes the product
//   product    out  64  unsigned a*b, stable while stalled
//   busy       out  1   high while running or holding a result
module mul32_seq_ctrl
  import mul_pkg::*;
#(
  parameter int ZERO_SKIP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MUL_W-1:0]     a,
  input  logic [MUL_W-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*MUL_W-1:0]   product,
  output logic                 busy
);

  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(MUL_ITERS - 1);

  mul_state_t            r_state;
  logic [MUL_W-1:0]      r_mcand;
  logic [MUL_W-1:0]      r_acc_hi;
  logic [MUL_W-1:0]      r_acc_lo;
  logic [MUL_CNT_W-1:0]  r_count;
  logic [2*MUL_W-1:0]    r_product;
  logic                  r_out_valid;

  mul_state_t            w_state_nxt;
  logic [MUL_W-1:0]      w_mcand_nxt;
  logic [MUL_W-1:0]      w_acc_hi_nxt;
  logic [MUL_W-1:0]      w_acc_lo_nxt;
  logic [MUL_CNT_W-1:0]  w_count_nxt;
  logic [2*MUL_W-1:0]    w_product_nxt;
  logic                  w_out_valid_nxt;

  logic [MUL_W-1:0]      w_sum;
  logic                  w_c_out;
  logic [2*MUL_W-1:0]    w_shift;
  logic                  w_zero_op;

  // The only adder in the unit: partial high word plus multiplicand.
  add32 u_add32 (
    .a     (r_acc_hi),
    .b     (r_mcand),
    .c_in  (1'b0),
    .sum   (w_sum),
    .c_out (w_c_out)
  );

  always_comb begin
    in_ready = (r_state == S_IDLE) && !rst;
    busy     = (r_state == S_RUN) || (r_state == S_DONE);
  end

  assign out_valid = r_out_valid;
  assign product   = r_product;

  assign w_zero_op = (ZERO_SKIP != 0) && ((a == '0) || (b == '0));

  // One iteration: the 65-bit {carry, sum, acc_lo} shifted right by one.
  // The adder carry lands in acc_hi[31], so nothing is lost.
  always_comb begin
    if (r_acc_lo[0]) begin
      w_shift = {w_c_out, w_sum, r_acc_lo[MUL_W-1:1]};
    end else begin
      w_shift = {1'b0, r_acc_hi, r_acc_lo[MUL_W-1:1]};
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_mcand_nxt     = r_mcand;
    w_acc_hi_nxt    = r_acc_hi;
    w_acc_lo_nxt    = r_acc_lo;
    w_count_nxt     = r_count;
    w_product_nxt   = r_product;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_mcand_nxt  = a;
          w_acc_hi_nxt = '0;
          w_acc_lo_nxt = b;
          w_count_nxt  = '0;
          if (w_zero_op) begin
            w_product_nxt   = '0;
            w_out_valid_nxt = 1'b1;
            w_state_nxt     = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        w_acc_hi_nxt = w_shift[2*MUL_W-1:MUL_W];
        w_acc_lo_nxt = w_shift[MUL_W-1:0];
        w_count_nxt  = r_count + MUL_CNT_W'(1);
        if (r_count == CNT_LAST) begin
          w_product_nxt   = w_shift;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_out_valid_nxt = 1'b0;
        w_state_nxt     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_acc_hi    <= '0;
      r_acc_lo    <= '0;
      r_count     <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mcand     <= w_mcand_nxt;
      r_acc_hi    <= w_acc_hi_nxt;
      r_acc_lo    <= w_acc_lo_nxt;
      r_count     <= w_count_nxt;
      r_product   <= w_product_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb/tb_mul32_seq_ctrl.sv - scoreboard bench for mul32_seq_ctrl
module tb_mul32_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a, b;
  logic [63:0] product;

  logic        z_in_valid, z_in_ready, z_out_valid, z_busy;
  logic [31:0] z_a, z_b;
  logic [63:0] z_product;

  always #5 clk = ~clk;

  mul32_seq_ctrl #(.ZERO_SKIP(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  mul32_seq_ctrl #(.ZERO_SKIP(0)) dut_nz (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .a(z_a), .b(z_b), .out_valid(z_out_valid), .out_ready(1'b1),
    .product(z_product), .busy(z_busy)
  );

  typedef struct {
    logic [63:0] exp;
    longint      lat;
    longint      acc_cyc;
  } txn_t;

  txn_t   sb[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     acc_cnt = 0;
  int     rdy_mode = 0;
  logic   prev_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Accept observer: reference model is plain 64-bit multiplication; a zero
  // operand on the skipping instance shows up one cycle after accept, every
  // other operation 33 cycles after accept (accept cycle counted as 1).
  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      txn_t t;
      t.exp     = {32'b0, a} * {32'b0, b};
      t.lat     = (a == 0 || b == 0) ? 1 : 33;
      t.acc_cyc = cyc;
      sb.push_back(t);
      acc_cnt++;
    end
  end

  // Monitor: drives out_ready, checks latency on the rising out_valid and
  // the product on each output handshake.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    if (out_valid && !prev_ov) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_out_valid: got product %h with nothing outstanding", product);
      end else begin
        chk("latency", 64'(cyc - sb[0].acc_cyc + 1), 64'(sb[0].lat));
      end
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      chk("product", product, sb[0].exp);
      void'(sb.pop_front());
    end
    prev_ov = out_valid;
  end

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb);
    int n0;
    int k;
    n0 = acc_cnt;
    k  = 0;
    @(negedge clk);
    a = xa; b = xb; in_valid = 1'b1;
    while (acc_cnt == n0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (acc_cnt == n0) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 400 cycles");
    end
    in_valid = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while ((sb.size() != 0 || !in_ready) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || !in_ready) begin
      checks++; errors++;
      $display("FAIL done_timeout: got %0d outstanding expected 0", sb.size());
    end
  endtask

  function automatic logic [31:0] pick_operand();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'($urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] hold_p;
    logic        seen, stable;
    int          k;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    z_in_valid = 1'b0; z_a = '0; z_b = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_product", product, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {63'b0, in_ready}, 64'd1);

    // 3 x 5, in_ready must stay low while the unit works
    do_op(32'd3, 32'd5);
    seen = 1'b0; k = 0;
    while (!out_valid && k < 100) begin
      if (in_ready) seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chk("in_ready_while_busy", {63'b0, seen}, 64'd0);
    wait_done();

    // all-ones operands exercise the adder carry
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done();

    // zero operand with skipping
    do_op(32'h0, 32'h1234);
    wait_done();

    // zero operand without skipping: full run
    @(negedge clk);
    z_a = 32'h0; z_b = 32'h1234; z_in_valid = 1'b1;
    chk("nz_in_ready", {63'b0, z_in_ready}, 64'd1);
    @(negedge clk);
    z_in_valid = 1'b0;
    k = 1;
    while (!z_out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("nz_latency", 64'(k), 64'd33);
    chk("nz_product", z_product, 64'd0);
    @(negedge clk);

    // output stall: held 10 cycles, then released
    rdy_mode = 2;
    do_op(32'h1234_5678, 32'h9ABC_DEF0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    hold_p = product;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!out_valid || product !== hold_p || in_ready) stable = 1'b0;
    end
    chk("stall_stable", {63'b0, stable}, 64'd1);
    chk("stall_product", hold_p, {32'b0, 32'h1234_5678} * {32'b0, 32'h9ABC_DEF0});
    rdy_mode = 0;
    @(negedge clk);
    @(negedge clk);
    chk("release_in_ready", {63'b0, in_ready}, 64'd1);
    chk("release_out_valid", {63'b0, out_valid}, 64'd0);

    // reset part-way through 7 x 9
    do_op(32'd7, 32'd9);
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    sb.delete();
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
    do_op(32'd2, 32'd21);
    wait_done();

    // random pairs with random output stalls
    rdy_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      do_op(pick_operand(), pick_operand());
    end
    wait_done();
    rdy_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
